// File: rtl/barrido_display.sv
// Time-multiplexed scan driver for N common-anode 7-segment digits.
// Optional leading-zero blanking is included; anodo and catodo are registered together.
module barrido_display #(
  parameter int N_DIGITOS      = 8,
  parameter int DIV_REFRESCO   = 100000,
  parameter int SUPRIMIR_CEROS = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*N_DIGITOS-1:0] digitos,
  input  logic                   carga,
  input  logic                   habilitado,
  output logic [N_DIGITOS-1:0]   anodo,
  output logic [6:0]             catodo
);

  localparam int IW = $clog2(N_DIGITOS);
  localparam int PW = $clog2(DIV_REFRESCO);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_REFRESCO - 1);
  localparam logic [IW-1:0] IND_MAX   = IW'(N_DIGITOS - 1);

  logic [3:0]           buffer [N_DIGITOS];
  logic [PW-1:0]        presc;
  logic [IW-1:0]        indice;
  logic [IW-1:0]        indice_sig;
  logic                 avanza;
  logic [N_DIGITOS-1:0] blanco;
  logic                 racha_ceros;
  logic [N_DIGITOS-1:0] anodo_sig;
  logic [6:0]           catodo_sig;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0:    seg7 = 7'b0000001;
      4'h1:    seg7 = 7'b1001111;
      4'h2:    seg7 = 7'b0010010;
      4'h3:    seg7 = 7'b0000110;
      4'h4:    seg7 = 7'b1001100;
      4'h5:    seg7 = 7'b0100100;
      4'h6:    seg7 = 7'b0100000;
      4'h7:    seg7 = 7'b0001111;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0000100;
      4'hA:    seg7 = 7'b1111110;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // carga is a plain level strobe: every edge with carga=1 captures digitos.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_DIGITOS; i++) buffer[i] <= '0;
    end else if (carga) begin
      for (int i = 0; i < N_DIGITOS; i++) buffer[i] <= digitos[4*i +: 4];
    end
  end

  always_comb begin
    avanza     = (presc == PRESC_MAX);
    indice_sig = indice;
    if (avanza) indice_sig = (indice == IND_MAX) ? '0 : indice + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc  <= '0;
      indice <= '0;
    end else begin
      presc  <= avanza ? '0 : presc + 1'b1;
      indice <= indice_sig;
    end
  end

  // Walk down from the top digit; the run of zeros ends at the first nonzero code (minus included).
  always_comb begin
    blanco      = '0;
    racha_ceros = 1'b1;
    for (int i = N_DIGITOS - 1; i >= 0; i--) begin
      racha_ceros = racha_ceros && (buffer[i] == 4'h0);
      blanco[i]   = (SUPRIMIR_CEROS != 0) && (i != 0) && racha_ceros;
    end
  end

  always_comb begin
    anodo_sig  = ~(N_DIGITOS'(1) << indice_sig);
    catodo_sig = blanco[indice_sig] ? 7'b1111111 : seg7(buffer[indice_sig]);
  end

  always_ff @(posedge clk) begin
    if (reset || !habilitado) begin
      anodo  <= '1;
      catodo <= 7'b1111111;
    end else begin
      anodo  <= anodo_sig;
      catodo <= catodo_sig;
    end
  end

endmodule

// File: tb/tb_barrido_display.sv
// Bench for barrido_display: two instances (plain and zero-blanking) share stimulus and
// are compared each cycle against a behavioural model through an expected queue.
module tb_barrido_display;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4*N-1:0] digitos;
  logic          carga;
  logic          habilitado;
  logic [N-1:0]  anodo, anodo_z;
  logic [6:0]    catodo, catodo_z;

  int checks   = 0;
  int failures = 0;

  // {anodo, catodo plain, catodo blanking}
  logic [17:0] exp_q[$];

  int          m_presc = 0;
  int          m_ind   = 0;
  logic [15:0] m_buf   = '0;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b1111110, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

  barrido_display #(.N_DIGITOS(N), .DIV_REFRESCO(DIV), .SUPRIMIR_CEROS(0)) dut (
    .clk(clk), .reset(reset), .digitos(digitos), .carga(carga),
    .habilitado(habilitado), .anodo(anodo), .catodo(catodo)
  );

  barrido_display #(.N_DIGITOS(N), .DIV_REFRESCO(DIV), .SUPRIMIR_CEROS(1)) dut_z (
    .clk(clk), .reset(reset), .digitos(digitos), .carga(carga),
    .habilitado(habilitado), .anodo(anodo_z), .catodo(catodo_z)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A position above the highest nonzero nibble is blanked when suppression is on.
  function automatic logic [6:0] ref_seg(input logic [15:0] b, input int pos, input bit supp);
    logic [3:0] d;
    int hi;
    d  = b[pos*4 +: 4];
    hi = -1;
    for (int j = 0; j < N; j++) if (b[j*4 +: 4] != 4'h0) hi = j;
    if (supp && pos > 0 && pos > hi) return 7'b1111111;
    return seg_tab[d];
  endfunction

  // driver + scoreboard: predict the next edge, push, clock, pop and compare
  task automatic tick();
    int          nxt;
    logic [3:0]  an;
    logic [17:0] e;
    if (reset) begin
      m_presc = 0;
      m_ind   = 0;
      m_buf   = '0;
      exp_q.push_back({4'hF, 7'h7F, 7'h7F});
    end else begin
      nxt = m_ind;
      if (m_presc == DIV - 1) nxt = (m_ind == N - 1) ? 0 : m_ind + 1;
      an = 4'b0001 << nxt;
      if (habilitado)
        exp_q.push_back({~an, ref_seg(m_buf, nxt, 1'b0), ref_seg(m_buf, nxt, 1'b1)});
      else
        exp_q.push_back({4'hF, 7'h7F, 7'h7F});
      if (carga) m_buf = digitos;
      m_presc = (m_presc == DIV - 1) ? 0 : m_presc + 1;
      m_ind   = nxt;
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("anodo",    32'(anodo),    32'(e[17:14]));
    chk("anodo_z",  32'(anodo_z),  32'(e[17:14]));
    chk("catodo",   32'(catodo),   32'(e[13:7]));
    chk("catodo_z", 32'(catodo_z), 32'(e[6:0]));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input logic [15:0] v);
    digitos = v;
    carga   = 1'b1;
    tick();
    carga   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; habilitado = 1'b1; carga = 1'b0; digitos = '0;
    run(3);
    chk("reset_anodo", 32'(anodo), 32'hF);
    chk("reset_catodo", 32'(catodo), 32'h7F);

    // first edge out of reset shows position 0 of an empty buffer
    reset = 1'b0;
    tick();
    chk("first_anodo", 32'(anodo), 32'hE);
    chk("first_catodo", 32'(catodo), 32'(7'b0000001));
    chk("first_catodo_z", 32'(catodo_z), 32'(7'b0000001));
    run(2);

    // scan, sign/blank and zero suppression patterns
    load(16'h4321); run(20);
    load(16'hA0F5); run(16);
    load(16'h0070); run(16);
    load(16'h0000); run(16);

    // load coinciding with an index advance: old digit for one cycle, then new
    load(16'h1111);
    while (m_presc != DIV - 1) tick();
    digitos = 16'h2222;
    carga   = 1'b1;
    tick();
    carga   = 1'b0;
    chk("adv_old_digit", 32'(catodo), 32'(7'b1001111));
    digitos = 16'h9999;
    tick();
    chk("adv_new_digit", 32'(catodo), 32'(7'b0010010));
    for (int i = 0; i < 10; i++) begin
      digitos = 16'($urandom_range(0, 16'hFFFF));
      tick();
    end

    // random loads and occasional enable drops
    for (int i = 0; i < 60; i++) begin
      digitos    = 16'($urandom_range(0, 16'hFFFF));
      carga      = ($urandom_range(0, 3) == 0);
      habilitado = ($urandom_range(0, 7) != 0);
      tick();
    end
    carga = 1'b0; habilitado = 1'b1;
    load(16'h8765); run(8);

    // disable: outputs dark one cycle later, prescaler keeps running
    habilitado = 1'b0;
    tick();
    chk("dis_anodo", 32'(anodo), 32'hF);
    chk("dis_catodo", 32'(catodo), 32'h7F);
    run(5);
    habilitado = 1'b1;
    run(12);

    // reset mid-dwell at position 2
    while (!(m_ind == 2 && m_presc == 1)) tick();
    reset = 1'b1;
    tick();
    chk("mid_reset_anodo", 32'(anodo), 32'hF);
    chk("mid_reset_catodo", 32'(catodo), 32'h7F);
    reset = 1'b0;
    tick();
    chk("restart_anodo", 32'(anodo), 32'hE);
    chk("restart_catodo", 32'(catodo), 32'(7'b0000001));
    run(20);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/barrido_display.md
BARRIDO_DISPLAY -- requirements
Module: barrido_display

Interface
REQ-001 The block SHALL have parameter N_DIGITOS, default 8, giving the number of multiplexed 7-segment digits (legal 2..16).
REQ-002 The block SHALL have parameter DIV_REFRESCO, default 100000, giving the clock cycles each digit stays lit (legal >= 2).
REQ-003 The block SHALL have parameter SUPRIMIR_CEROS, default 0, where 1 enables leading-zero blanking.
REQ-004 The block SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port digitos  input  4*N_DIGITOS  digit codes; nibble i drives digit position i, with position 0 least significant.
REQ-007 The block SHALL have port carga  input  1  load strobe that captures digitos into the display buffer.
REQ-008 The block SHALL have port habilitado  input  1  display enable; 0 turns off all anodes.
REQ-009 The block SHALL have port anodo  output  N_DIGITOS  active-low digit selects.
REQ-010 The block SHALL have port catodo  output  7  active-low segments, with bit 6 = a through bit 0 = g.

Function
REQ-011 The buffer SHALL be an N_DIGITOS x 4 register loaded from digitos on every clock edge where carga=1 and reset=0, and held otherwise.
REQ-012 Prescaler presc SHALL count 0..DIV_REFRESCO-1 and wrap to 0; it counts regardless of habilitado.
REQ-013 Scan index indice SHALL advance by 1 on the edge where presc = DIV_REFRESCO-1, and wrap from N_DIGITOS-1 to 0.
REQ-014 anodo and catodo SHALL be registered outputs, both updated on the same edge, computed from the post-edge indice and the pre-edge buffer; there is no skew between them.
REQ-015 If carga=1 on edge k, the new data SHALL first appear on catodo at edge k+1; a carga coinciding with an index advance shows the old buffer for one cycle only.
REQ-016 When habilitado=1, anodo SHALL equal the inverse of a one-hot with bit indice set.
REQ-017 When habilitado=0, anodo SHALL be all ones and catodo SHALL be 7'b1111111, registered with the same one-cycle latency.
REQ-018 Segment encoding SHALL be:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- 1010 (minus) = 1111110
- 1011..1111 (blank) = 1111111
REQ-019 With SUPRIMIR_CEROS=1, position i>0 SHALL be blanked (1111111) when buffer nibbles N_DIGITOS-1 down to i are all 0000.
REQ-020 Position 0 SHALL never be zero-suppressed.
REQ-021 A minus code (1010) SHALL end the leading-zero run, so zeros below it are displayed.
REQ-022 With SUPRIMIR_CEROS=0, every digit SHALL be decoded per REQ-018.
REQ-023 The dwell time per digit SHALL be exactly DIV_REFRESCO cycles, and one full frame SHALL take N_DIGITOS*DIV_REFRESCO cycles.

Reset
REQ-024 On an edge with reset=1, presc, indice and buffer SHALL become 0, anodo SHALL become all ones, and catodo SHALL become 1111111.
REQ-025 reset SHALL take priority over carga and habilitado.
REQ-026 A reset asserted mid-dwell or mid-frame SHALL restart the scan at position 0 with a full dwell once reset deasserts.
REQ-027 After reset deasserts with habilitado=1, the first edge SHALL drive anodo = ~1 and catodo = the decoded buffer[0], which is 0 and therefore 0000001, or 1111111 if blanked.

Verification (N_DIGITOS=4, DIV_REFRESCO=4)
REQ-028 Scan: carga digitos=16'h4321, habilitado=1 -> anodo steps 1110, 1101, 1011, 0111, 1110, each held 4 cycles; catodo steps 1001111, 0010010, 0000110, 1001100.
REQ-029 Sign and blank: digitos=16'hA0F5 -> position 3 shows 1111110, position 2 shows 0000001, position 1 shows 1111111, position 0 shows 0100100.
REQ-030 Zero suppression (SUPRIMIR_CEROS=1): digitos=16'h0070 -> positions 3 and 2 show 1111111, position 1 shows 0001111, position 0 shows 0000001; digitos=16'h0000 -> only position 0 shows 0000001.
REQ-031 Load timing: pulse carga for one cycle at the index-advance edge with digitos changing from 16'h1111 to 16'h2222 -> catodo shows 1001111 for one cycle, then 0010010; digitos changes while carga=0 do not alter the display.
REQ-032 Enable and reset: deassert habilitado -> one cycle later anodo=1111 and catodo=1111111 while presc keeps counting; assert reset mid-dwell at indice=2 -> next edge gives all outputs and buffer at reset values, and the scan restarts at position 0.
